// File: rtl/cpu_pkg.sv
// Shared definitions for the core's memory-port arbiter.
//   mem_arb_state_t : arbiter FSM states
//   mem_owner_t     : which requester owns / last owned the memory port
//   *_WIDTH_DEF     : default address / data widths
package cpu_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INSTR_BUSY = 2'd1,
        DATA_BUSY  = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } mem_owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog for the memory-port arbiter.
// Counts BUSY cycles that end without mem_done and flags a timeout in the
// BUSY cycle where the count reaches TIMEOUT_CYCLES-1 with no mem_done.
// A mem_done in that same cycle wins, so timeout is suppressed.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : hold counter at zero (asserted while the arbiter is idle)
//   busy_i     : a transaction is outstanding downstream
//   mem_done_i : downstream completion (already qualified by mem_req)
//   timeout_o  : combinational timeout for the current cycle
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic busy_i,
    input  logic mem_done_i,
    output logic timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (busy_i && !mem_done_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = busy_i && !mem_done_i && (cnt_q == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store requests.
// One transaction at a time; the response is routed back to its owner as a
// one-cycle done pulse (with err on watchdog timeout). Instruction responses
// made stale by flush_pipeline are swallowed.
//
// Optional feature: define MEM_PORT_ARBITER_RR_EN for round-robin arbitration
// between simultaneous requests; otherwise data always wins.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   flush_pipeline                    drop in-flight/pending fetch response
//   instruction_*                     fetch request / response
//   data_*                            load/store request / response
//   mem_req, mem_addr, mem_write,
//   mem_wdata, mem_wstrb              registered downstream request
//   mem_rdata, mem_done               downstream response
//
// state      | meaning
// -----------+-------------------------------------------------
// IDLE       | no transaction; arbitrate and capture the winner
// INSTR_BUSY | fetch owns the port, mem_req high
// DATA_BUSY  | load/store owns the port, mem_req high
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_pipeline,
    input  logic [ADDR_WIDTH-1:0]     instruction_addr,
    input  logic                      instruction_fetch_activate,
    output logic [DATA_WIDTH-1:0]     instruction_data,
    output logic                      instruction_fetch_done,
    output logic                      instruction_fetch_err,
    input  logic [ADDR_WIDTH-1:0]     data_addr,
    input  logic                      data_activate,
    input  logic                      data_write,
    input  logic [DATA_WIDTH-1:0]     data_wdata,
    input  logic [DATA_WIDTH/8-1:0]   data_wstrb,
    output logic [DATA_WIDTH-1:0]     data_rdata,
    output logic                      data_done,
    output logic                      data_err,
    output logic                      mem_req,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_write,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_done
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    mem_arb_state_t          state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    discard_q, discard_d;

    logic grant_instr;
    logic grant_data;
    logic busy;
    logic done_valid;
    logic timeout;
    logic complete;
    logic instr_quiet;
    logic instr_fin;
    logic data_fin;

`ifdef MEM_PORT_ARBITER_RR_EN
    mem_owner_t last_grant_q, last_grant_d;
`endif

    always_comb begin
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        if (state_q == IDLE) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            if (instruction_fetch_activate && data_activate) begin
                // contended: whoever was not granted last goes next
                grant_data  = (last_grant_q == OWNER_INSTR);
                grant_instr = (last_grant_q == OWNER_DATA);
            end else begin
                grant_data  = data_activate;
                grant_instr = instruction_fetch_activate;
            end
`else
            grant_data  = data_activate;
            grant_instr = instruction_fetch_activate && !data_activate;
`endif
        end
    end

`ifdef MEM_PORT_ARBITER_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_data) begin
            last_grant_d = OWNER_DATA;
        end else if (grant_instr) begin
            last_grant_d = OWNER_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= OWNER_INSTR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign busy       = (state_q != IDLE);
    // mem_done only means something while a request is outstanding
    assign done_valid = mem_req_q && mem_done;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (!busy),
        .busy_i     (busy),
        .mem_done_i (done_valid),
        .timeout_o  (timeout)
    );

    assign complete  = busy && (done_valid || timeout);
    assign instr_fin = (state_q == INSTR_BUSY) && complete;
    assign data_fin  = (state_q == DATA_BUSY) && complete;
    // a flush in the completing cycle also makes that response stale
    assign instr_quiet = discard_q || flush_pipeline;

    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d   = DATA_BUSY;
                    mem_req_d = 1'b1;
                    addr_d    = data_addr;
                    write_d   = data_write;
                    wdata_d   = data_wdata;
                    wstrb_d   = data_wstrb;
                    discard_d = 1'b0;
                end else if (grant_instr) begin
                    state_d   = INSTR_BUSY;
                    mem_req_d = 1'b1;
                    addr_d    = instruction_addr;
                    write_d   = 1'b0;
                    wdata_d   = '0;
                    wstrb_d   = '0;
                    discard_d = flush_pipeline;
                end
            end
            INSTR_BUSY, DATA_BUSY: begin
                if (complete) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                end else if ((state_q == INSTR_BUSY) && flush_pipeline) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                discard_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            discard_q <= discard_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = addr_q;
    assign mem_write = write_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    assign instruction_fetch_done = instr_fin && !instr_quiet;
    assign instruction_fetch_err  = instruction_fetch_done && timeout;
    assign instruction_data       = (instruction_fetch_done && !timeout) ? mem_rdata : '0;

    assign data_done  = data_fin;
    assign data_err   = data_fin && timeout;
    assign data_rdata = (data_fin && !timeout) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int T = 4;
`ifdef MEM_PORT_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_pipeline;
    logic [31:0] instruction_addr;
    logic        instruction_fetch_activate;
    logic [31:0] instruction_data;
    logic        instruction_fetch_done;
    logic        instruction_fetch_err;
    logic [31:0] data_addr;
    logic        data_activate;
    logic        data_write;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        data_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .flush_pipeline             (flush_pipeline),
        .instruction_addr           (instruction_addr),
        .instruction_fetch_activate (instruction_fetch_activate),
        .instruction_data           (instruction_data),
        .instruction_fetch_done     (instruction_fetch_done),
        .instruction_fetch_err      (instruction_fetch_err),
        .data_addr                  (data_addr),
        .data_activate              (data_activate),
        .data_write                 (data_write),
        .data_wdata                 (data_wdata),
        .data_wstrb                 (data_wstrb),
        .data_rdata                 (data_rdata),
        .data_done                  (data_done),
        .data_err                   (data_err),
        .mem_req                    (mem_req),
        .mem_addr                   (mem_addr),
        .mem_write                  (mem_write),
        .mem_wdata                  (mem_wdata),
        .mem_wstrb                  (mem_wstrb),
        .mem_rdata                  (mem_rdata),
        .mem_done                   (mem_done)
    );

    typedef struct {
        bit          ia;
        logic [31:0] iaddr;
        bit          da;
        bit          dw;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        bit          fl;
        bit          md;
        logic [31:0] mrd;
        bit          ereq;
        logic [31:0] eaddr;
        bit          ewr;
        logic [3:0]  ewstrb;
        logic [31:0] ewdata;
        int          who;    // 0 none, 1 instruction done, 2 data done
        bit          eerr;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit ia, logic [31:0] iaddr, bit da, bit dw, logic [31:0] daddr,
                               logic [31:0] dwdata, bit fl, bit md, logic [31:0] mrd,
                               bit ereq, logic [31:0] eaddr, bit ewr, logic [3:0] ewstrb,
                               logic [31:0] ewdata, int who, bit eerr, logic [31:0] erd);
        vec_t r;
        r.ia = ia; r.iaddr = iaddr; r.da = da; r.dw = dw; r.daddr = daddr; r.dwdata = dwdata;
        r.fl = fl; r.md = md; r.mrd = mrd; r.ereq = ereq; r.eaddr = eaddr; r.ewr = ewr;
        r.ewstrb = ewstrb; r.ewdata = ewdata; r.who = who; r.eerr = eerr; r.erd = erd;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input bit ereq, input logic [31:0] eaddr, input bit ewr,
                                 input logic [3:0] ewstrb, input logic [31:0] ewdata,
                                 input int who, input bit eerr, input logic [31:0] erd);
        check("mem_req", 64'(mem_req), 64'(ereq));
        if (ereq) begin
            check("mem_addr", 64'(mem_addr), 64'(eaddr));
            check("mem_write", 64'(mem_write), 64'(ewr));
            check("mem_wstrb", 64'(mem_wstrb), 64'(ewstrb));
            if (ewr) check("mem_wdata", 64'(mem_wdata), 64'(ewdata));
        end
        check("ifetch_done", 64'(instruction_fetch_done), 64'(who == 1));
        check("ifetch_err", 64'(instruction_fetch_err), 64'(who == 1 && eerr));
        check("ifetch_data", 64'(instruction_data), 64'((who == 1) ? erd : 32'h0));
        check("data_done", 64'(data_done), 64'(who == 2));
        check("data_err", 64'(data_err), 64'(who == 2 && eerr));
        check("data_rdata", 64'(data_rdata), 64'((who == 2) ? erd : 32'h0));
    endtask

    task automatic drive(input bit ia, input logic [31:0] iaddr, input bit da, input bit dw,
                         input logic [31:0] daddr, input logic [31:0] dwdata, input logic [3:0] dstrb,
                         input bit fl, input bit md, input logic [31:0] mrd);
        instruction_fetch_activate = ia;
        instruction_addr           = iaddr;
        data_activate              = da;
        data_write                 = dw;
        data_addr                  = daddr;
        data_wdata                 = dwdata;
        data_wstrb                 = dstrb;
        flush_pipeline             = fl;
        mem_done                   = md;
        mem_rdata                  = mrd;
    endtask

    // transaction-level reference state
    int          m_owner;
    int          m_cnt;
    bit          m_stale;
    int          m_last;
    logic [31:0] m_addr, m_wdata;
    bit          m_write;
    logic [3:0]  m_wstrb;

    initial begin
        // instruction fetch
        vecs.push_back(v(1,32'h100,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0));
        vecs.push_back(v(1,32'h100,0,0,0,0,0,0,0,            1,32'h100,0,0,0,0,0,0));
        vecs.push_back(v(1,32'h100,0,0,0,0,0,0,0,            1,32'h100,0,0,0,0,0,0));
        vecs.push_back(v(1,32'h100,0,0,0,0,0,1,32'hDEADBEEF, 1,32'h100,0,0,0,1,0,32'hDEADBEEF));
        vecs.push_back(v(0,0,0,0,0,0,0,0,32'hDEADBEEF,       0,0,0,0,0,0,0,0));
        // simultaneous: data store first, then instruction after an idle gap
        vecs.push_back(v(1,32'h300,1,1,32'h200,32'h12345678,0,0,0, 0,0,0,0,0,0,0,0));
        vecs.push_back(v(1,32'h300,1,1,32'h200,32'h12345678,0,1,32'hA5A5A5A5,
                         1,32'h200,1,4'hF,32'h12345678,2,0,32'hA5A5A5A5));
        vecs.push_back(v(1,32'h300,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0));
        vecs.push_back(v(1,32'h300,0,0,0,0,0,1,32'h11112222, 1,32'h300,0,0,0,1,0,32'h11112222));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,                  0,0,0,0,0,0,0,0));
        // flush during fetch, then a clean fetch
        vecs.push_back(v(1,32'h400,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0));
        vecs.push_back(v(1,32'h400,0,0,0,0,1,0,0,            1,32'h400,0,0,0,0,0,0));
        vecs.push_back(v(1,32'h400,0,0,0,0,0,1,32'h77777777, 1,32'h400,0,0,0,0,0,0));
        vecs.push_back(v(1,32'h104,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0));
        vecs.push_back(v(1,32'h104,0,0,0,0,0,1,32'hCAFEF00D, 1,32'h104,0,0,0,1,0,32'hCAFEF00D));
        vecs.push_back(v(0,0,0,0,0,0,0,0,0,                  0,0,0,0,0,0,0,0));
        // watchdog: no mem_done for 4 busy cycles
        vecs.push_back(v(0,0,1,0,32'h500,0,0,0,0,            0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0,0,1,0,32'h500,0,0,0,32'hFFFFFFFF, 1,32'h500,0,4'hF,0,0,0,0));
        vecs.push_back(v(0,0,1,0,32'h500,0,0,0,32'hFFFFFFFF, 1,32'h500,0,4'hF,0,2,1,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,32'hFFFFFFFF,       0,0,0,0,0,0,0,0));
        // watchdog: mem_done in the last allowed cycle wins
        vecs.push_back(v(0,0,1,0,32'h504,0,0,0,0,            0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0,0,1,0,32'h504,0,0,0,0,        1,32'h504,0,4'hF,0,0,0,0));
        vecs.push_back(v(0,0,1,0,32'h504,0,0,1,32'h0BADF00D, 1,32'h504,0,4'hF,0,2,0,32'h0BADF00D));
        // mem_done while idle is ignored
        vecs.push_back(v(0,0,0,0,0,0,0,1,32'h12121212,       0,0,0,0,0,0,0,0));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_mem_addr", 64'(mem_addr), 64'h0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'h0);
        check("rst_mem_wstrb", 64'(mem_wstrb), 64'h0);
        check("rst_mem_write", 64'(mem_write), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].ia, vecs[k].iaddr, vecs[k].da, vecs[k].dw, vecs[k].daddr,
                  vecs[k].dwdata, 4'hF, vecs[k].fl, vecs[k].md, vecs[k].mrd);
            #1;
            check_outputs(vecs[k].ereq, vecs[k].eaddr, vecs[k].ewr, vecs[k].ewstrb,
                          vecs[k].ewdata, vecs[k].who, vecs[k].eerr, vecs[k].erd);
            @(negedge clk);
        end

        // reset in the middle of a data transaction
        drive(0, 0, 1, 1, 32'h600, 32'h55AA55AA, 4'h3, 0, 0, 0);
        @(negedge clk);
        #1;
        check("mid_req_before_rst", 64'(mem_req), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_req_in_rst", 64'(mem_req), 64'h0);
        mem_done  = 1'b1;
        mem_rdata = 32'h1234;
        #1;
        check("mid_done_in_rst", 64'(data_done), 64'h0);
        @(negedge clk);
        check("mid_addr_in_rst", 64'(mem_addr), 64'h0);
        check("mid_write_in_rst", 64'(mem_write), 64'h0);
        check("mid_wstrb_in_rst", 64'(mem_wstrb), 64'h0);
        check("mid_done_hold", 64'(data_done), 64'h0);
        drive(1, 32'h700, 1, 1, 32'h600, 32'h55AA55AA, 4'h3, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_outputs(1, 32'h600, 1, 4'h3, 32'h55AA55AA, 0, 0, 0);
        mem_done  = 1'b1;
        mem_rdata = 32'h600D600D;
        #1;
        check_outputs(1, 32'h600, 1, 4'h3, 32'h55AA55AA, 2, 0, 32'h600D600D);
        @(negedge clk);
        data_activate = 1'b0;
        mem_done      = 1'b0;
        #1;
        check_outputs(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        mem_done  = 1'b1;
        mem_rdata = 32'h70707070;
        #1;
        check_outputs(1, 32'h700, 0, 4'h0, 0, 1, 0, 32'h70707070);
        @(negedge clk);
        instruction_fetch_activate = 1'b0;
        mem_done = 1'b0;
        #1;
        check_outputs(0, 0, 0, 0, 0, 0, 0, 0);

        // randomized run against the reference model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_owner = 0; m_cnt = 0; m_stale = 0; m_last = 1;
        m_addr = 0; m_wdata = 0; m_write = 0; m_wstrb = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          ia, da, dw, fl, md, to, fin;
            logic [31:0] ia_a, da_a, dwd, mrd;
            logic [3:0]  dst;
            int          who, win;
            ia   = bit'($urandom_range(0, 1));
            da   = ($urandom_range(0, 2) == 0);
            dw   = bit'($urandom_range(0, 1));
            ia_a = $urandom;
            da_a = $urandom;
            dwd  = $urandom;
            dst  = 4'($urandom);
            fl   = ($urandom_range(0, 9) == 0);
            md   = ($urandom_range(0, 3) == 0);
            mrd  = $urandom;
            drive(ia, ia_a, da, dw, da_a, dwd, dst, fl, md, mrd);
            #1;
            fin = (m_owner != 0) && (md || m_cnt == T - 1);
            to  = (m_owner != 0) && !md && (m_cnt == T - 1);
            who = 0;
            if (fin) begin
                if (m_owner == 2) who = 2;
                else if (!(m_stale || fl)) who = 1;
            end
            check_outputs(m_owner != 0, m_addr, m_write, m_wstrb, m_wdata, who, to, to ? 32'h0 : mrd);
            @(posedge clk);
            if (m_owner == 0) begin
                if (ia && da) win = RR ? ((m_last == 1) ? 2 : 1) : 2;
                else if (da) win = 2;
                else if (ia) win = 1;
                else win = 0;
                if (win != 0) begin
                    m_owner = win;
                    m_last  = win;
                    m_cnt   = 0;
                    m_stale = (win == 1) && fl;
                    if (win == 2) begin
                        m_addr = da_a; m_write = dw; m_wdata = dwd; m_wstrb = dst;
                    end else begin
                        m_addr = ia_a; m_write = 0; m_wstrb = 4'h0;
                    end
                end
            end else if (fin) begin
                m_owner = 0;
                m_stale = 0;
            end else begin
                m_cnt++;
                if (m_owner == 1 && fl) m_stale = 1;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the fetch stage (read-only instruction requests) and the memory stage (load/store data requests). It accepts one request at a time and sequences it on the downstream port. Each response is routed back to the requester that issued it, as a one-cycle done pulse. The block also discards instruction responses made stale by a pipeline flush, and aborts downstream transactions that hang, using a watchdog.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 256, maximum number of cycles mem_req stays high for one transaction; must be ≥ 1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous and active-low
- flush_pipeline  in  1  discards any in-flight or pending instruction response
- instruction_addr  in  ADDR_WIDTH  fetch address
- instruction_fetch_activate  in  1  fetch request; held high by requester until done
- instruction_data  out  DATA_WIDTH  fetch read data; valid only with done
- instruction_fetch_done  out  1  one-cycle fetch completion pulse
- instruction_fetch_err  out  1  fetch timed out; pulses together with done
- data_addr  in  ADDR_WIDTH  load/store address
- data_activate  in  1  data request; held high until done
- data_write  in  1  1 = store, 0 = load
- data_wdata  in  DATA_WIDTH  store data
- data_wstrb  in  DATA_WIDTH/8  store byte enables
- data_rdata  out  DATA_WIDTH  load data; valid only with done
- data_done  out  1  one-cycle data completion pulse
- data_err  out  1  data request timed out; pulses together with done
- mem_req  out  1  downstream request, registered
- mem_addr, mem_write, mem_wdata, mem_wstrb  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  registered request fields
- mem_rdata  in  DATA_WIDTH  downstream read data
- mem_done  in  1  downstream completion; sampled only while mem_req is high

## Operation
- The FSM has three states: IDLE, INSTR_BUSY and DATA_BUSY.
- In IDLE, when any activate is high, the winner is selected. Its address, write data, strobes and write flag are captured into the mem_* registers, and the FSM moves to the matching BUSY state. Instruction captures force mem_write=0 and mem_wstrb=0.
- Default arbitration is fixed priority: the data requester wins whenever both are requesting.
- In a BUSY state, mem_req=1.
  - On mem_done, the owner's done pulses in that cycle. Its read data passes mem_rdata through combinationally, and the FSM returns to IDLE.
  - On a timeout, the owner's done and err pulse together, its read data reads as 0, mem_req drops, and the FSM returns to IDLE.
- Watchdog:
  - The counter clears on entry to a BUSY state and increments on each BUSY cycle without mem_done.
  - A timeout fires in the BUSY cycle where the count equals TIMEOUT_CYCLES-1 and mem_done is low.
  - If mem_done arrives in that same cycle, it wins and no error is reported.
- Discard flag:
  - Set when flush_pipeline is high in INSTR_BUSY.
  - Also set when flush_pipeline is high in the IDLE cycle that grants an instruction request.
  - While the flag is set, the transaction runs to completion (or timeout) downstream, but instruction_fetch_done and instruction_fetch_err stay low.
  - The flag clears on return to IDLE.
- Data transactions are never affected by flush_pipeline.
- A mem_done received while in IDLE is ignored.
- Outputs when idle: done/err outputs are 0 whenever not owner-completing; read data outputs read 0 when their done is low.

## Timing
- Reset (asynchronous, rst_n low) returns:
  - FSM to IDLE
  - mem_req, mem_write and all done/err outputs to 0
  - mem_addr, mem_wdata and mem_wstrb to 0
  - watchdog counter and discard flag to 0
- Reset asserted mid-transaction drops mem_req immediately, and no done pulse is produced for that transaction.
- Latency:
  - Activate seen in IDLE at cycle N gives mem_req=1 from cycle N+1.
  - The done pulse comes in the cycle mem_done is high; the minimum is cycle N+1.
- Throughput: at least one IDLE cycle separates transactions, so the peak rate is one transaction every 2 cycles.
- An activate still high in the IDLE cycle after its done is treated as a new request.
- Activate and request fields are sampled only in IDLE; changes during BUSY are ignored.

## Configuration
- MEM_PORT_ARBITER_RR_EN defined: round-robin arbitration.
  - A last-grant bit is updated at each grant and reset to "instruction".
  - On simultaneous requests, the requester not granted last wins.
- MEM_PORT_ARBITER_RR_EN undefined: fixed data priority, and no last-grant register exists.

## Structure
- Shared package cpu_pkg holds:
  - the mem_arb_state_t enum (IDLE, INSTR_BUSY, DATA_BUSY)
  - the ADDR_WIDTH/DATA_WIDTH defaults
  - the mem_owner_t enum (OWNER_INSTR, OWNER_DATA)
- Sub-module mem_arb_watchdog:
  - parameterised by TIMEOUT_CYCLES, with counter width $clog2(TIMEOUT_CYCLES+1)
  - inputs: clear, busy, mem_done
  - output: timeout
- The FSM, capture registers and response routing stay in the top module.

## Test plan
- Instruction fetch: instruction_fetch_activate=1, address 0x100; mem_done with rdata 0xDEADBEEF two cycles after mem_req -> mem_addr=0x100, mem_write=0; instruction_fetch_done pulses once with 0xDEADBEEF; FSM back to IDLE.
- Simultaneous requests: both activates high in IDLE, data store to 0x200 with wdata 0x12345678 and strobe 0xF:
  - without RR -> data granted first, instruction second, with the one-cycle IDLE gap between them
  - with RR from reset -> data is granted first (last grant resets to instruction), then instruction
- Flush: flush_pipeline pulsed during INSTR_BUSY, then mem_done -> no instruction_fetch_done; the next fetch to 0x104 completes normally.
- Watchdog: TIMEOUT_CYCLES=4 and no mem_done -> mem_req high exactly 4 cycles; data_done and data_err pulse in the 4th cycle with data_rdata=0. Repeat with mem_done in the 4th cycle -> done without err.
- Reset mid-transaction: rst_n low during DATA_BUSY -> mem_req=0 immediately and no done pulse. Release reset with data_activate still high -> a new grant is made and the request completes normally.
